alu_seq: RTL
============

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, datapath width; legal values 4, 8, 16, 32 (powers of two).
REQ-002 SHALL have derived local parameter SHW = clog2(WIDTH), the shift-amount width.
REQ-003 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operation request.
REQ-006 SHALL have port in_ready  output  1  block can accept an operation.
REQ-007 SHALL have ports a and b  input  WIDTH  operands.
REQ-008 SHALL have port op  input  3  opcode (see REQ-013).
REQ-009 SHALL have port shamt  input  SHW  shift amount for shift ops; ignored otherwise.
REQ-010 SHALL have port out_valid  output  1  result and flags are valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-012 SHALL have ports result (WIDTH), carry, overflow, zero and negative (1 each), all outputs, all registered.

Function
REQ-013 SHALL decode op as follows: 000 ADD, 001 SUB (a-b), 010 AND, 011 OR, 100 SHL, 101 SHR logical, 110 SRA arithmetic, 111 MUL (unsigned, low WIDTH bits).
REQ-014 SHALL use an FSM with states IDLE, EXEC and DONE.
REQ-015 SHALL drive in_ready=1 only in IDLE.
REQ-016 SHALL accept an operation, capturing a, b, op and shamt, on a cycle where in_valid and in_ready are both 1.
REQ-017 SHALL, for ADD/SUB/AND/OR and for shifts with shamt=0, go IDLE->DONE so that out_valid=1 on the cycle after accept (latency 1).
REQ-018 SHALL, for shifts with shamt>0, go IDLE->EXEC and shift one bit per cycle, reaching DONE after shamt cycles (latency shamt+1).
REQ-019 SHALL, for MUL, go IDLE->EXEC and perform a shift-add over WIDTH cycles (latency WIDTH+1).
REQ-020 SHALL keep result and flags stable in DONE until out_valid and out_ready are both 1, then go to IDLE; no new accept is allowed on that cycle.
REQ-021 SHALL ignore in_valid while in EXEC or DONE, with no state change.
REQ-022 SHALL set carry for ADD to bit WIDTH of the (WIDTH+1)-bit sum.
REQ-023 SHALL set carry for SUB to 1 when there is no borrow (a>=b unsigned), computed as a + ~b + 1.
REQ-024 SHALL set overflow for ADD/SUB as two's-complement signed overflow.
REQ-025 SHALL set carry for shifts to the last bit shifted out, and to 0 when shamt=0.
REQ-026 SHALL set carry for MUL to 1 when the upper WIDTH bits of the 2*WIDTH product are nonzero.
REQ-027 SHALL force carry=0 for AND/OR and overflow=0 for all ops other than ADD/SUB.
REQ-028 SHALL set zero = (result==0) and negative = result[WIDTH-1], registered together with result.

Reset
REQ-029 SHALL, on rst=1 at a clock edge, go to IDLE and clear result, all flags, out_valid and internal counters.
REQ-030 SHALL, on rst, drive in_ready=1 from the following cycle.
REQ-031 SHALL, on rst during EXEC or DONE, abort the operation, with no out_valid for it ever.
REQ-032 SHALL give rst priority over any simultaneous handshake.

Structure
REQ-033 SHALL take the opcode constants and FSM state encoding from shared package alu_pkg.
REQ-034 SHALL implement the single-cycle ops (ADD/SUB/AND/OR, flag generation) in one combinational sub-module, alu_core, parametrised by WIDTH.
REQ-035 SHALL keep the shift/MUL iteration counter SHW+1 bits wide.

Verification (WIDTH=8)
REQ-036 SHALL check ADD a=0x7F b=0x01 -> result 0x80, overflow=1, carry=0, negative=1; out_valid 1 cycle after accept.
REQ-037 SHALL check SUB a=0x05 b=0x05 -> result 0x00, zero=1, carry=1, overflow=0.
REQ-038 SHALL check SHL a=0x81 shamt=3 -> result 0x08, carry=0, out_valid 4 cycles after accept; and SRA a=0x80 shamt=7 -> result 0xFF, negative=1.
REQ-039 SHALL check MUL a=0x10 b=0x11 -> result 0x10, carry=1, out_valid 9 cycles after accept.
REQ-040 SHALL check that holding out_ready=0 for 5 cycles in DONE keeps result and flags stable and in_ready=0, and that in_valid pulses in that window are dropped.
REQ-041 SHALL check rst=1 on the 4th cycle of a MUL -> next cycle out_valid=0, in_ready=1, result=0x00; no result ever appears for the aborted MUL.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode and FSM state definitions for the sequential ALU.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_SHL = 3'b100,
    OP_SHR = 3'b101,
    OP_SRA = 3'b110,
    OP_MUL = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // True for the three shift opcodes, which iterate only when shamt is nonzero.
  function automatic logic is_shift(input op_e op);
    return (op == OP_SHL) || (op == OP_SHR) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational single-cycle ALU: ADD/SUB/AND/OR with flags. Any other opcode
// passes operand a through with carry clear, which is exactly the result of a
// zero-distance shift.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  op_e              op_i,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o,
  output logic             overflow_o,
  output logic             zero_o,
  output logic             negative_o
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH:0] add_sum;
  logic [WIDTH:0] sub_sum;

  // Subtraction as a + ~b + 1 so that the carry out means "no borrow".
  assign add_sum = {1'b0, a_i} + {1'b0, b_i};
  assign sub_sum = {1'b0, a_i} + {1'b0, ~b_i} + (WIDTH+1)'(1);

  // Opcode decode and flag generation.
  always_comb begin
    result_o   = a_i;
    carry_o    = 1'b0;
    overflow_o = 1'b0;
    case (op_i)
      OP_ADD: begin
        result_o   = add_sum[MSB:0];
        carry_o    = add_sum[WIDTH];
        overflow_o = (a_i[MSB] == b_i[MSB]) && (add_sum[MSB] != a_i[MSB]);
      end
      OP_SUB: begin
        result_o   = sub_sum[MSB:0];
        carry_o    = sub_sum[WIDTH];
        overflow_o = (a_i[MSB] != b_i[MSB]) && (sub_sum[MSB] != a_i[MSB]);
      end
      OP_AND: result_o = a_i & b_i;
      OP_OR:  result_o = a_i | b_i;
      default: result_o = a_i;
    endcase
    zero_o     = (result_o == '0);
    negative_o = result_o[MSB];
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes. Single-cycle ops resolve in the
// combinational core; shifts walk one bit per cycle and MUL runs a shift-add
// loop, both in EXEC, before the registered result is presented in DONE.
module alu_seq
  import alu_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int CNT_W = SHW + 1;
  localparam int MSB   = WIDTH - 1;

  state_e             state_q;
  op_e                op_q;
  logic [WIDTH-1:0]   a_q;
  logic [2*WIDTH-1:0] work_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [WIDTH-1:0]   result_q;
  logic               carry_q;
  logic               overflow_q;
  logic               zero_q;
  logic               negative_q;

  op_e                op_in;
  logic [WIDTH-1:0]   core_result;
  logic               core_carry;
  logic               core_overflow;
  logic               core_zero;
  logic               core_negative;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] work_d;
  logic               iter_carry_d;
  logic [WIDTH-1:0]   iter_result_d;

  assign op_in = op_e'(op);

  alu_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .a_i       (a),
    .b_i       (b),
    .op_i      (op_in),
    .result_o  (core_result),
    .carry_o   (core_carry),
    .overflow_o(core_overflow),
    .zero_o    (core_zero),
    .negative_o(core_negative)
  );

  // One iteration step. Shifts use the low half of work_q; MUL keeps the
  // partial product in the upper half and the remaining multiplier bits in the
  // lower half, retiring one multiplier bit per cycle.
  always_comb begin
    mul_sum      = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, a_q} : '0);
    work_d       = work_q;
    iter_carry_d = 1'b0;
    case (op_q)
      OP_SHL: begin
        work_d       = {{WIDTH{1'b0}}, work_q[MSB-1:0], 1'b0};
        iter_carry_d = work_q[MSB];
      end
      OP_SHR: begin
        work_d       = {{WIDTH{1'b0}}, 1'b0, work_q[MSB:1]};
        iter_carry_d = work_q[0];
      end
      OP_SRA: begin
        work_d       = {{WIDTH{1'b0}}, work_q[MSB], work_q[MSB:1]};
        iter_carry_d = work_q[0];
      end
      OP_MUL: begin
        work_d       = {mul_sum, work_q[MSB:1]};
        iter_carry_d = |mul_sum[WIDTH:1];
      end
      default: begin
        work_d       = work_q;
        iter_carry_d = 1'b0;
      end
    endcase
    iter_result_d = work_d[MSB:0];
  end

  // Control FSM with registered handshake, result and flag outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_ADD;
      a_q         <= '0;
      work_q      <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
      negative_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            op_q       <= op_in;
            a_q        <= a;
            in_ready_q <= 1'b0;
            if (op_in == OP_MUL) begin
              work_q  <= {{WIDTH{1'b0}}, b};
              cnt_q   <= CNT_W'(WIDTH);
              state_q <= ST_EXEC;
            end else if (is_shift(op_in) && (shamt != '0)) begin
              work_q  <= {{WIDTH{1'b0}}, a};
              cnt_q   <= {1'b0, shamt};
              state_q <= ST_EXEC;
            end else begin
              result_q    <= core_result;
              carry_q     <= core_carry;
              overflow_q  <= core_overflow;
              zero_q      <= core_zero;
              negative_q  <= core_negative;
              out_valid_q <= 1'b1;
              state_q     <= ST_DONE;
            end
          end
        end
        ST_EXEC: begin
          work_q <= work_d;
          cnt_q  <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            result_q    <= iter_result_d;
            carry_q     <= iter_carry_d;
            overflow_q  <= 1'b0;
            zero_q      <= (iter_result_d == '0);
            negative_q  <= iter_result_d[MSB];
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign carry     = carry_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;
  assign negative  = negative_q;

endmodule
